frame_fifo: RTL and testbench
=============================

# frame_fifo

Multi-channel FIFO of fixed-size sample frames between the audio I/O buffers and the DSP cores. The writer fills the head frame at random offsets and commits it; the reader reads the tail frame at random offsets and releases it. Unlike the earlier chunk FIFO, it adds:
- parametrised channel count;
- full/empty/occupancy status;
- overflow/underflow protection with sticky error flags;
- registered read data with a valid strobe;
- a synchronous flush.

All logic runs on one clock edge.

## Interface
- SAMPLE_SIZE, 24, bits per channel sample
- CHANNELS, 2, channels per sample word; word width W = SAMPLE_SIZE*CHANNELS
- FRAME_SIZE, 64, samples per frame
- FRAME_PTR_BITS, $clog2(FRAME_SIZE), in-frame offset width
- FIFO_DEPTH, 16, frames held; any value ≥2, not necessarily a power of two
- FIFO_PTR_BITS, $clog2(FIFO_DEPTH), frame index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous empty; same effect as rst, except the error flags are preserved
- fill  in  1  write write_sample at write_ptr in the head frame
- fill_done  in  1  commit the head frame
- write_sample  in  W  sample word; channel c is in bits [c*SAMPLE_SIZE +: SAMPLE_SIZE]
- write_ptr  in  FRAME_PTR_BITS  offset within the head frame
- read  in  1  read request at read_ptr in the tail frame
- read_done  in  1  release the tail frame
- read_ptr  in  FRAME_PTR_BITS  offset within the tail frame
- read_sample  out  W  registered read data
- read_valid  out  1  read_sample updated this cycle
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- count  out  FIFO_PTR_BITS+1  committed frames held
- overflow  out  1  sticky; a commit was dropped
- underflow  out  1  sticky; a read or release was attempted while empty

## Operation
- Storage: one array of FIFO_DEPTH*FRAME_SIZE words of width W.
  - Address is head*FRAME_SIZE + write_ptr for writes and tail*FRAME_SIZE + read_ptr for reads.
  - Storage is not reset.
- Head, tail and count are registers. Head and tail wrap explicitly from FIFO_DEPTH-1 to 0.
- Write:
  - When fill && !full, the word is stored.
  - When fill && full, nothing is stored.
- Commit:
  - When fill_done && !full, head increments.
  - When fill_done && full, the frame is dropped: head is unchanged and overflow is set.
- Read:
  - When read && !empty, read_sample takes the stored word at the next edge and read_valid=1.
  - When read && empty, read_sample holds, read_valid=0 and underflow is set.
- Release:
  - When read_done && !empty, tail increments.
  - When read_done && empty, tail is unchanged and underflow is set.
- count update per cycle: count + commit_accepted − release_accepted.
  - Commit and release accepted in the same cycle: count unchanged, both pointers advance.
  - A commit while full is never accepted, even with a simultaneous release. The writer retries after full drops.
- Same-cycle accesses:
  - Read and write in the same cycle to different frames are independent.
  - A read of the frame being committed in that cycle returns old storage.
- Priority: rst > flush > normal operation.
- Flush clears head, tail, count, read_valid and read_sample. overflow and underflow hold; only rst clears them.
- Out-of-range pointers (≥FRAME_SIZE when not a power of two) are not supported. Behaviour with them is undefined.

## Timing
- Reset values: read_sample=0, read_valid=0, full=0, empty=1, count=0, overflow=0, underflow=0, head=tail=0.
- Read latency: read_sample and read_valid appear 1 cycle after read. read_valid is high for exactly one cycle per accepted read.
- Status outputs are registered or decoded from registered count.
  - full, empty and count reflect an accepted commit or release 1 cycle after the strobe.
- Back-to-back strobes:
  - fill_done may be high on consecutive cycles; each high cycle is a separate commit.
  - The same holds for read_done: each high cycle is a separate release.
- Reset mid-operation: a read in flight is cancelled, and read_valid is 0 on the cycle after rst.
- A frame committed in cycle N is readable from cycle N+1.

## Test plan
- Reset, then commit one frame of 64 words (word k = {24'(k), 24'(k+100)}) and read offsets 0..63 → each read_sample matches after 1 cycle with read_valid=1; count=1, then 0 after read_done; empty=1.
- Fill and commit 16 frames, frame f word k = f*64+k → full=1, count=16. A 17th fill_done sets overflow, count stays 16, and frame 0 still reads 0..63.
- With count=16, assert fill_done and read_done in the same cycle → count=15, overflow=1, head unchanged, tail=1.
- With count=3, assert fill_done and read_done together → count stays 3 and both pointers advance. Repeat 20 times and check the head/tail wrap 15→0.
- With the FIFO empty, pulse read and read_done → read_valid=0, read_sample unchanged, underflow=1, tail=0. Then flush → underflow still 1. Then rst → underflow=0.
- With FIFO_DEPTH=5, CHANNELS=4: commit 5 frames, release 5, repeated 3 times → wrap at 4→0, data intact, full and empty toggle correctly.

Source files
------------

// File: rtl/frame_fifo.sv
// Multi-channel FIFO of fixed-size sample frames: the writer fills and commits the
// head frame, the reader reads and releases the tail frame, both at random offsets.
module frame_fifo #(
  parameter int SAMPLE_SIZE    = 24,
  parameter int CHANNELS       = 2,
  parameter int FRAME_SIZE     = 64,
  parameter int FRAME_PTR_BITS = $clog2(FRAME_SIZE),
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_PTR_BITS  = $clog2(FIFO_DEPTH),
  localparam int W             = SAMPLE_SIZE * CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fill,
  input  logic                      fill_done,
  input  logic [W-1:0]              write_sample,
  input  logic [FRAME_PTR_BITS-1:0] write_ptr,
  input  logic                      read,
  input  logic                      read_done,
  input  logic [FRAME_PTR_BITS-1:0] read_ptr,
  output logic [W-1:0]              read_sample,
  output logic                      read_valid,
  output logic                      full,
  output logic                      empty,
  output logic [FIFO_PTR_BITS:0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH * FRAME_SIZE);
  localparam int CW     = FIFO_PTR_BITS + 1;
  localparam logic [FIFO_PTR_BITS-1:0] LAST_IDX  = FIFO_PTR_BITS'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]            DEPTH_CNT = CW'(FIFO_DEPTH);

  logic [W-1:0] mem [FIFO_DEPTH * FRAME_SIZE];

  logic [FIFO_PTR_BITS-1:0] head_q, head_d;
  logic [FIFO_PTR_BITS-1:0] tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic [W-1:0]             read_sample_q, read_sample_d;
  logic                     read_valid_q, read_valid_d;

  logic              write_ok, read_ok, commit_ok, release_ok;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  assign write_ok   = fill && !full;
  assign commit_ok  = fill_done && !full;
  assign read_ok    = read && !empty;
  assign release_ok = read_done && !empty;

  // Multiply rather than concatenate so FIFO_DEPTH and FRAME_SIZE need not be powers of two.
  assign wr_addr = ADDR_W'(head_q) * ADDR_W'(FRAME_SIZE) + ADDR_W'(write_ptr);
  assign rd_addr = ADDR_W'(tail_q) * ADDR_W'(FRAME_SIZE) + ADDR_W'(read_ptr);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + CW'(commit_ok) - CW'(release_ok);
    overflow_d    = overflow_q | (fill_done && full);
    underflow_d   = underflow_q | ((read || read_done) && empty);
    read_valid_d  = read_ok;
    read_sample_d = read_sample_q;
    if (commit_ok) begin
      head_d = (head_q == LAST_IDX) ? '0 : head_q + FIFO_PTR_BITS'(1);
    end
    if (release_ok) begin
      tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + FIFO_PTR_BITS'(1);
    end
    if (read_ok) begin
      read_sample_d = mem[rd_addr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      read_sample_q <= '0;
      read_valid_q  <= 1'b0;
    end else if (flush) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      read_sample_q <= '0;
      read_valid_q  <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      read_sample_q <= read_sample_d;
      read_valid_q  <= read_valid_d;
    end
  end

  // NOTE: the frame store has no reset so it maps onto plain RAM; reads of never-written words are undefined.
  always_ff @(posedge clk) begin
    if (write_ok && !rst && !flush) begin
      mem[wr_addr] <= write_sample;
    end
  end

  assign read_sample = read_sample_q;
  assign read_valid  = read_valid_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_frame_fifo.sv
// Directed bench for frame_fifo: default 16x64x2ch instance plus a 5-deep, 4-channel instance.
module tb_frame_fifo;

  logic        clk;
  logic        rst, flush, fill, fill_done, read, read_done;
  logic [47:0] write_sample, read_sample;
  logic [5:0]  write_ptr, read_ptr;
  logic        read_valid, full, empty, overflow, underflow;
  logic [4:0]  count;

  logic        rst5, flush5, fill5, fill_done5, read5, read_done5;
  logic [95:0] write_sample5, read_sample5;
  logic [5:0]  write_ptr5, read_ptr5;
  logic        read_valid5, full5, empty5, overflow5, underflow5;
  logic [3:0]  count5;

  int checks = 0;
  int errors = 0;

  frame_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .fill(fill), .fill_done(fill_done),
    .write_sample(write_sample), .write_ptr(write_ptr), .read(read), .read_done(read_done),
    .read_ptr(read_ptr), .read_sample(read_sample), .read_valid(read_valid), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  frame_fifo #(.CHANNELS(4), .FIFO_DEPTH(5)) dut5 (
    .clk(clk), .rst(rst5), .flush(flush5), .fill(fill5), .fill_done(fill_done5),
    .write_sample(write_sample5), .write_ptr(write_ptr5), .read(read5), .read_done(read_done5),
    .read_ptr(read_ptr5), .read_sample(read_sample5), .read_valid(read_valid5), .full(full5),
    .empty(empty5), .count(count5), .overflow(overflow5), .underflow(underflow5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; fill = 0; fill_done = 0; read = 0; read_done = 0;
    write_ptr = '0; read_ptr = '0; write_sample = '0;
  endtask

  task automatic test_reset();
    rst = 1; rst5 = 1;
    tick(); tick();
    rst = 0; rst5 = 0;
    checks++; if (read_sample !== 48'd0) begin errors++; $display("FAIL reset_read_sample: got %h expected 0", read_sample); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_read_valid: got %b expected 0", read_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    checks++; if ({empty5, full5, count5} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL reset5_status: got %b/%b/%0d expected 1/0/0", empty5, full5, count5); end
  endtask

  task automatic test_single_frame();
    for (int k = 0; k < 64; k++) begin
      fill = 1; write_ptr = 6'(k); write_sample = {24'(k), 24'(k + 100)};
      tick();
    end
    fill = 0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_precommit_count: got %0d expected 0", count); end
    fill_done = 1; tick(); fill_done = 0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
    for (int k = 0; k < 64; k++) begin
      read = 1; read_ptr = 6'(k);
      tick();
      checks++;
      if ({read_valid, read_sample} !== {1'b1, 24'(k), 24'(k + 100)}) begin
        errors++; $display("FAIL single_read[%0d]: got v=%b %h expected v=1 %h", k, read_valid, read_sample, {24'(k), 24'(k + 100)});
      end
    end
    read = 0; tick();
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", read_valid); end
    checks++; if (read_sample !== {24'd63, 24'd163}) begin errors++; $display("FAIL single_sample_hold: got %h expected %h", read_sample, {24'd63, 24'd163}); end
    read_done = 1; tick(); read_done = 0;
    checks++; if ({count, empty, underflow} !== {5'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL single_release: got count=%0d empty=%b uf=%b expected 0/1/0", count, empty, underflow); end
  endtask

  task automatic test_full_overflow();
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < 64; k++) begin
        fill = 1; write_ptr = 6'(k); write_sample = 48'(f * 64 + k);
        tick();
      end
      fill = 0;
      fill_done = 1; tick(); fill_done = 0;
      if (f == 14) begin
        checks++; if ({full, count} !== {1'b0, 5'd15}) begin errors++; $display("FAIL full_at15: got full=%b count=%0d expected 0/15", full, count); end
      end
    end
    checks++; if ({full, count, empty, overflow} !== {1'b1, 5'd16, 1'b0, 1'b0}) begin errors++; $display("FAIL full_at16: got full=%b count=%0d empty=%b ovf=%b expected 1/16/0/0", full, count, empty, overflow); end
    fill = 1; write_ptr = 6'd0; write_sample = 48'hDEAD_BEEF;
    tick(); fill = 0;
    fill_done = 1; tick(); fill_done = 0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    checks++; if ({full, count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL overflow_count: got full=%b count=%0d expected 1/16", full, count); end
    for (int k = 0; k < 64; k++) begin
      read = 1; read_ptr = 6'(k);
      tick();
      checks++;
      if ({read_valid, read_sample} !== {1'b1, 48'(k)}) begin
        errors++; $display("FAIL full_frame0[%0d]: got v=%b %h expected v=1 %h", k, read_valid, read_sample, 48'(k));
      end
    end
    read = 0;
  endtask

  task automatic test_simul_full();
    fill_done = 1; read_done = 1; tick(); fill_done = 0; read_done = 0;
    checks++; if ({count, full, overflow} !== {5'd15, 1'b0, 1'b1}) begin errors++; $display("FAIL simfull_status: got count=%0d full=%b ovf=%b expected 15/0/1", count, full, overflow); end
    read = 1; read_ptr = 6'd5; tick(); read = 0;
    checks++; if (read_sample !== 48'(64 + 5)) begin errors++; $display("FAIL simfull_tail: got %h expected %h", read_sample, 48'(69)); end
    // New frame must land in the released slot, not on top of frame 1.
    for (int k = 0; k < 64; k++) begin
      fill = 1; write_ptr = 6'(k); write_sample = 48'h00AB_C000 + 48'(k);
      tick();
    end
    fill = 0;
    fill_done = 1; tick(); fill_done = 0;
    checks++; if ({full, count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL simfull_refill: got full=%b count=%0d expected 1/16", full, count); end
    for (int f = 1; f < 16; f++) begin
      read = 1; read_done = 1; read_ptr = 6'(f);
      tick();
      checks++;
      if ({read_valid, read_sample} !== {1'b1, 48'(f * 64 + f)}) begin
        errors++; $display("FAIL simfull_drain[%0d]: got v=%b %h expected v=1 %h", f, read_valid, read_sample, 48'(f * 64 + f));
      end
    end
    read = 1; read_done = 1; read_ptr = 6'd7;
    tick(); read = 0; read_done = 0;
    checks++; if (read_sample !== 48'h00AB_C007) begin errors++; $display("FAIL simfull_head: got %h expected 00abc007", read_sample); end
    checks++; if ({count, empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL simfull_empty: got count=%0d empty=%b expected 0/1", count, empty); end
  endtask

  task automatic test_simul_wrap();
    for (int s = 0; s < 3; s++) begin
      fill = 1; fill_done = 1; write_ptr = 6'd0; write_sample = 48'(500 + s);
      tick();
    end
    idle();
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL wrap_setup: got count=%0d expected 3", count); end
    for (int i = 0; i < 20; i++) begin
      read = 1; read_ptr = 6'd0; read_done = 1;
      fill = 1; write_ptr = 6'd0; write_sample = 48'(503 + i); fill_done = 1;
      tick();
      checks++;
      if ({read_valid, read_sample, count} !== {1'b1, 48'(500 + i), 5'd3}) begin
        errors++; $display("FAIL wrap_iter[%0d]: got v=%b %0d count=%0d expected v=1 %0d count=3", i, read_valid, read_sample, count, 500 + i);
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      read = 1; read_ptr = 6'd0; read_done = 1;
      tick();
      checks++;
      if (read_sample !== 48'(520 + i)) begin errors++; $display("FAIL wrap_drain[%0d]: got %0d expected %0d", i, read_sample, 520 + i); end
    end
    idle();
    checks++; if ({count, empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL wrap_empty: got count=%0d empty=%b expected 0/1", count, empty); end
  endtask

  task automatic test_underflow_flush();
    read = 1; read_done = 1; read_ptr = 6'd3;
    tick(); idle();
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL uf_valid: got %b expected 0", read_valid); end
    checks++; if (read_sample !== 48'd522) begin errors++; $display("FAIL uf_sample_hold: got %0d expected 522", read_sample); end
    checks++; if ({underflow, count, empty} !== {1'b1, 5'd0, 1'b1}) begin errors++; $display("FAIL uf_status: got uf=%b count=%0d empty=%b expected 1/0/1", underflow, count, empty); end
    fill = 1; fill_done = 1; write_ptr = 6'd0; write_sample = 48'd77;
    tick(); idle();
    read = 1; read_ptr = 6'd0; tick(); read = 0;
    checks++; if ({read_valid, read_sample, count} !== {1'b1, 48'd77, 5'd1}) begin errors++; $display("FAIL uf_tail_kept: got v=%b %0d count=%0d expected v=1 77 count=1", read_valid, read_sample, count); end
    flush = 1; read = 1; read_ptr = 6'd0;
    tick(); idle();
    checks++; if ({read_valid, read_sample} !== {1'b0, 48'd0}) begin errors++; $display("FAIL flush_read: got v=%b %h expected v=0 0", read_valid, read_sample); end
    checks++; if ({count, empty, full} !== {5'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL flush_status: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
    checks++; if ({underflow, overflow} !== 2'b11) begin errors++; $display("FAIL flush_flags: got uf=%b ovf=%b expected 1/1", underflow, overflow); end
    rst = 1; tick(); rst = 0;
    checks++; if ({underflow, overflow} !== 2'b00) begin errors++; $display("FAIL rst_flags: got uf=%b ovf=%b expected 0/0", underflow, overflow); end
  endtask

  task automatic test_reset_midread();
    fill = 1; fill_done = 1; write_ptr = 6'd0; write_sample = 48'd88;
    tick(); idle();
    read = 1; read_ptr = 6'd0; rst = 1;
    tick(); read = 0; rst = 0;
    checks++; if ({read_valid, read_sample} !== {1'b0, 48'd0}) begin errors++; $display("FAIL midread_cancel: got v=%b %h expected v=0 0", read_valid, read_sample); end
    checks++; if ({count, empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL midread_status: got count=%0d empty=%b expected 0/1", count, empty); end
    tick();
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL midread_after: got %b expected 0", read_valid); end
  endtask

  task automatic test_depth5();
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < 5; f++) begin
        for (int k = 0; k < 64; k++) begin
          fill5 = 1; write_ptr5 = 6'(k);
          write_sample5 = {24'(f + 1), 24'(r + 1), 24'(k), 24'(k + 7)};
          tick();
        end
        fill5 = 0;
        fill_done5 = 1; tick(); fill_done5 = 0;
        if (f == 3) begin
          checks++; if ({full5, count5} !== {1'b0, 4'd4}) begin errors++; $display("FAIL d5_at4[r%0d]: got full=%b count=%0d expected 0/4", r, full5, count5); end
        end
      end
      checks++; if ({full5, empty5, count5} !== {1'b1, 1'b0, 4'd5}) begin errors++; $display("FAIL d5_full[r%0d]: got full=%b empty=%b count=%0d expected 1/0/5", r, full5, empty5, count5); end
      for (int f = 0; f < 5; f++) begin
        int k;
        k = (f * 13) % 64;
        read5 = 1; read_done5 = 1; read_ptr5 = 6'(k);
        tick();
        checks++;
        if ({read_valid5, read_sample5} !== {1'b1, 24'(f + 1), 24'(r + 1), 24'(k), 24'(k + 7)}) begin
          errors++; $display("FAIL d5_read[r%0d f%0d]: got v=%b %h expected v=1 %h", r, f, read_valid5, read_sample5, {24'(f + 1), 24'(r + 1), 24'(k), 24'(k + 7)});
        end
        checks++;
        if ({count5, empty5, full5} !== {4'(4 - f), (f == 4), 1'b0}) begin
          errors++; $display("FAIL d5_release[r%0d f%0d]: got count=%0d empty=%b full=%b expected %0d/%b/0", r, f, count5, empty5, full5, 4 - f, (f == 4));
        end
      end
      read5 = 0; read_done5 = 0;
    end
    checks++; if ({overflow5, underflow5} !== 2'b00) begin errors++; $display("FAIL d5_flags: got ovf=%b uf=%b expected 0/0", overflow5, underflow5); end
  endtask

  initial begin
    idle();
    rst = 1;
    flush5 = 0; fill5 = 0; fill_done5 = 0; read5 = 0; read_done5 = 0;
    write_sample5 = '0; write_ptr5 = '0; read_ptr5 = '0; rst5 = 1;
    test_reset();
    test_single_frame();
    test_full_overflow();
    test_simul_full();
    test_simul_wrap();
    test_underflow_flush();
    test_reset_midread();
    test_depth5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
